cnu_serial_ms: RTL and testbench



---
 rtl/cnu_serial_ms.sv | 167 ++++++++++++++++
 tb/tb_cnu_serial_ms.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnu_serial_ms.sv
// rtl/cnu_serial_ms.sv - serial min-sum LDPC check node unit (optional offset min-sum via CNU_OFFSET_EN)
module cnu_serial_ms #(
  parameter int DEG    = 6,
  parameter int W      = 8,
  parameter int OFFSET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_data,
  output logic [$clog2(DEG)-1:0]  out_idx,
  output logic                    out_last
);

  localparam int CW = $clog2(DEG);
  localparam int MW = W - 1;
  localparam logic [MW-1:0] MAG_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   idx_q, idx_d;
  logic [MW-1:0]   min1_q, min1_d;
  logic [MW-1:0]   min2_q, min2_d;
  logic            parity_q, parity_d;
  logic [DEG-1:0]  sign_q;
  logic [W-1:0]    out_data_q;
  logic [CW-1:0]   out_idx_q;
  logic            out_valid_q, out_last_q;

  logic [MW-1:0]   mag;
  logic [W-1:0]    neg_data;
  logic            sgn;
  logic            in_fire;
  logic            last_in;
  logic [CW-1:0]   nxt_idx;

`ifndef CNU_OFFSET_EN
  logic [31:0]     unused_offset;
  assign unused_offset = OFFSET;
`endif

  // Accept input only outside EMIT and never while reset is asserted
  assign in_ready  = rst_n && (state_q != EMIT);
  assign in_fire   = in_valid && in_ready;
  assign last_in   = (state_q == ACCUM) && (cnt_q == CW'(DEG - 1));
  assign nxt_idx   = out_idx_q + CW'(1);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

  // Sign and saturated magnitude of the incoming message
  always_comb begin
    sgn      = in_data[W-1];
    neg_data = -in_data;
    if (!sgn)
      mag = in_data[MW-1:0];
    else if (in_data[MW-1:0] == '0)
      mag = MAG_MAX;
    else
      mag = neg_data[MW-1:0];
  end

  // Running min1/min2/index/parity including the current message
  always_comb begin
    min1_d   = min1_q;
    min2_d   = min2_q;
    idx_d    = idx_q;
    parity_d = parity_q ^ sgn;
    if (state_q == IDLE) begin
      min1_d   = mag;
      min2_d   = MAG_MAX;
      idx_d    = '0;
      parity_d = sgn;
    end else if (mag < min1_q) begin
      min2_d = min1_q;
      min1_d = mag;
      idx_d  = cnt_q;
    end else if (mag < min2_q) begin
      min2_d = mag;
    end
  end

  // Check-to-variable message for edge j: other-edge minimum with extrinsic sign
  function automatic logic [W-1:0] r_msg(input logic [CW-1:0] j, input logic [CW-1:0] id,
                                         input logic [MW-1:0] mn1, input logic [MW-1:0] mn2,
                                         input logic neg);
    logic [MW-1:0] m;
    m = (j == id) ? mn2 : mn1;
`ifdef CNU_OFFSET_EN
    m = (m > MW'(OFFSET)) ? m - MW'(OFFSET) : '0;
`endif
    return neg ? -{1'b0, m} : {1'b0, m};
  endfunction

  // Frame FSM: accumulate DEG messages, then stream DEG registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      min1_q      <= '0;
      min2_q      <= '0;
      parity_q    <= 1'b0;
      sign_q      <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            min1_q   <= min1_d;
            min2_q   <= min2_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            sign_q   <= {{(DEG-1){1'b0}}, sgn};
            cnt_q    <= CW'(1);
            state_q  <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            min1_q        <= min1_d;
            min2_q        <= min2_d;
            idx_q         <= idx_d;
            parity_q      <= parity_d;
            sign_q[cnt_q] <= sgn;
            cnt_q         <= cnt_q + CW'(1);
            if (last_in) begin
              cnt_q       <= '0;
              state_q     <= EMIT;
              out_valid_q <= 1'b1;
              out_idx_q   <= '0;
              out_last_q  <= 1'b0;
              out_data_q  <= r_msg('0, idx_d, min1_d, min2_d, parity_d ^ sign_q[0]);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              out_idx_q   <= '0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
            end else begin
              out_idx_q  <= nxt_idx;
              out_last_q <= (nxt_idx == CW'(DEG - 1));
              out_data_q <= r_msg(nxt_idx, idx_q, min1_q, min2_q, parity_q ^ sign_q[nxt_idx]);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnu_serial_ms.sv
// tb/tb_cnu_serial_ms.sv - self-checking bench for cnu_serial_ms (DEG=6, W=8)
module tb_cnu_serial_ms;

  localparam int DEG    = 6;
  localparam int W      = 8;
  localparam int OFFSET = 1;
  localparam int MAXM   = 2 ** (W - 1) - 1;

  typedef logic signed [W-1:0] frame_t [DEG];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [2:0]   out_idx;
  logic         out_last;

  int n_vec = 0;
  int n_err = 0;

  cnu_serial_ms #(.DEG(DEG), .W(W), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: each R is the minimum |Q| over the other edges, signed by the XOR of the other signs
  function automatic frame_t model(input frame_t q);
    frame_t r;
    int mn, mag, s;
    for (int j = 0; j < DEG; j++) begin
      mn = MAXM;
      s  = 0;
      for (int k = 0; k < DEG; k++) begin
        if (k != j) begin
          mag = int'(q[k]);
          if (mag < 0) mag = -mag;
          if (mag > MAXM) mag = MAXM;
          if (mag < mn) mn = mag;
          if (q[k] < 0) s = s ^ 1;
        end
      end
`ifdef CNU_OFFSET_EN
      mn = (mn > OFFSET) ? mn - OFFSET : 0;
`endif
      r[j] = W'(s != 0 ? -mn : mn);
    end
    return r;
  endfunction

  function automatic frame_t rand_frame();
    frame_t q;
    for (int k = 0; k < DEG; k++) begin
      case ($urandom_range(3))
        0:       q[k] = 8'sh80;
        1:       q[k] = W'($urandom_range(16) - 8);
        default: q[k] = W'($urandom);
      endcase
    end
    return q;
  endfunction

  // Drive edges k0..DEG-1 of q; returns at the negedge before the last acceptance commits
  task automatic feed_frame(input frame_t q, input int k0, input int gap_pct, output bit ok);
    int k, cyc;
    k = k0; cyc = 0; ok = 1'b1;
    while (k < DEG) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = ($urandom_range(99) >= gap_pct);
      in_data   = q[k];
      @(negedge clk);
      if (in_valid && in_ready) k++;
      cyc++;
      if (cyc > 500) begin ok = 1'b0; break; end
    end
  endtask

  // Capture DEG output transfers with random out_ready
  task automatic collect_frame(input int rdy_pct, output frame_t d, output int idx[DEG],
                               output bit last[DEG], output bit first_valid,
                               output bit busy_ok, output bit ok);
    int j, cyc;
    bit first;
    j = 0; cyc = 0; first = 1'b1; ok = 1'b1; busy_ok = 1'b1; first_valid = 1'b0;
    for (int i = 0; i < DEG; i++) begin d[i] = '0; idx[i] = -1; last[i] = 1'b0; end
    while (j < DEG) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      if (first) begin first_valid = out_valid; first = 1'b0; end
      if (out_valid && in_ready) busy_ok = 1'b0;
      if (out_valid && out_ready) begin
        d[j] = out_data; idx[j] = int'(out_idx); last[j] = out_last; j++;
      end
      cyc++;
      if (cyc > 500) begin ok = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %h want 00", out_data); end
    n_vec++; if (out_idx !== 3'd0) begin n_err++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
    n_vec++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %b want 0", out_last); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed(input string name, input frame_t q, input frame_t exp);
    frame_t d; int idx[DEG]; bit last[DEG]; bit fv, busy, ok1, ok2;
    feed_frame(q, 0, 0, ok1);
    collect_frame(100, d, idx, last, fv, busy, ok2);
    n_vec++; if (!(ok1 && ok2)) begin n_err++; $display("FAIL %s_timeout in=%b out=%b want 1 1", name, ok1, ok2); end
    n_vec++; if (fv !== 1'b1) begin n_err++; $display("FAIL %s_latency out_valid got %b want 1", name, fv); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s_in_ready_in_emit got high want low", name); end
    for (int j = 0; j < DEG; j++) begin
      n_vec++; if (d[j] !== exp[j]) begin n_err++; $display("FAIL %s_data[%0d] got %0d want %0d", name, j, $signed(d[j]), exp[j]); end
      n_vec++; if (idx[j] != j) begin n_err++; $display("FAIL %s_idx[%0d] got %0d want %0d", name, j, idx[j], j); end
      n_vec++; if (last[j] !== (j == DEG - 1)) begin n_err++; $display("FAIL %s_last[%0d] got %b want %b", name, j, last[j], j == DEG - 1); end
    end
  endtask

  task automatic test_random_gaps();
    frame_t q, exp, d; int idx[DEG]; bit last[DEG]; bit fv, busy, ok1, ok2;
    for (int f = 0; f < 20; f++) begin
      q = rand_frame();
      exp = model(q);
      feed_frame(q, 0, 50, ok1);
      collect_frame(60, d, idx, last, fv, busy, ok2);
      n_vec++; if (!(ok1 && ok2)) begin n_err++; $display("FAIL rnd%0d_timeout in=%b out=%b want 1 1", f, ok1, ok2); end
      n_vec++; if (fv !== 1'b1) begin n_err++; $display("FAIL rnd%0d_latency out_valid got %b want 1", f, fv); end
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rnd%0d_in_ready_in_emit got high want low", f); end
      for (int j = 0; j < DEG; j++) begin
        n_vec++; if (d[j] !== exp[j]) begin n_err++; $display("FAIL rnd%0d_data[%0d] got %0d want %0d", f, j, $signed(d[j]), exp[j]); end
        n_vec++; if (idx[j] != j || last[j] !== (j == DEG - 1)) begin n_err++; $display("FAIL rnd%0d_idx_last[%0d] got %0d/%b want %0d/%b", f, j, idx[j], last[j], j, j == DEG - 1); end
      end
    end
  endtask

  task automatic test_backpressure();
    frame_t q, exp; bit ok; int j, stall, cyc;
    q = rand_frame();
    exp = model(q);
    feed_frame(q, 0, 0, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL bp_feed_timeout got 0 want 1"); end
    j = 0; stall = 0; cyc = 0;
    while (j < DEG && cyc < 100) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = !(j == 2 && stall < 3);
      @(negedge clk);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid edge %0d got %b want 1", j, out_valid); end
      n_vec++; if (out_data !== exp[j] || out_idx !== 3'(j)) begin n_err++; $display("FAIL bp_data_idx edge %0d got %0d@%0d want %0d@%0d", j, $signed(out_data), out_idx, exp[j], j); end
      if (out_ready) j++;
      else begin
        stall++;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
      end
      cyc++;
    end
    n_vec++; if (j != DEG || stall != 3) begin n_err++; $display("FAIL bp_progress got %0d edges %0d stalls want %0d 3", j, stall, DEG); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle got ready=%b valid=%b want 1 0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    frame_t q1, q2, e2, d; int idx[DEG]; bit last[DEG]; bit fv, busy, ok1, ok2, ok3;
    q1 = rand_frame();
    q2 = rand_frame();
    e2 = model(q2);
    feed_frame(q1, 0, 0, ok1);
    collect_frame(100, d, idx, last, fv, busy, ok2);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = q2[0];
    @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_no_bubble in_ready got %b want 1", in_ready); end
    feed_frame(q2, 1, 0, ok3);
    collect_frame(100, d, idx, last, fv, busy, ok2);
    n_vec++; if (!(ok1 && ok2 && ok3)) begin n_err++; $display("FAIL b2b_timeout got %b%b%b want 111", ok1, ok2, ok3); end
    n_vec++; if (fv !== 1'b1) begin n_err++; $display("FAIL b2b_latency out_valid got %b want 1", fv); end
    for (int j = 0; j < DEG; j++) begin
      n_vec++; if (d[j] !== e2[j]) begin n_err++; $display("FAIL b2b_data[%0d] got %0d want %0d", j, $signed(d[j]), e2[j]); end
    end
  endtask

  task automatic test_reset_mid();
    frame_t q, exp, d; int idx[DEG]; bit last[DEG]; bit fv, busy, ok1, ok2;
    q = rand_frame();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = W'($urandom);
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_handshake got ready=%b valid=%b want 0 0", in_ready, out_valid); end
    n_vec++; if (out_data !== 8'h00 || out_idx !== 3'd0 || out_last !== 1'b0) begin n_err++; $display("FAIL rstmid_outputs got %h/%0d/%b want 00/0/0", out_data, out_idx, out_last); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp = model(q);
    feed_frame(q, 0, 30, ok1);
    collect_frame(80, d, idx, last, fv, busy, ok2);
    n_vec++; if (!(ok1 && ok2)) begin n_err++; $display("FAIL rstmid_timeout in=%b out=%b want 1 1", ok1, ok2); end
    for (int j = 0; j < DEG; j++) begin
      n_vec++; if (d[j] !== exp[j]) begin n_err++; $display("FAIL rstmid_data[%0d] got %0d want %0d", j, $signed(d[j]), exp[j]); end
    end
  endtask

  initial begin
    frame_t qa, ea, qb, eb;
    qa = '{8'sd5, -8'sd3, 8'sd7, -8'sd9, 8'sd2, 8'sd4};
    qb = '{8'sh80, 8'sd4, 8'sd4, 8'sd10, 8'sd20, 8'sd30};
`ifdef CNU_OFFSET_EN
    ea = '{8'sd1, -8'sd1, 8'sd1, -8'sd1, 8'sd2, 8'sd1};
    eb = '{8'sd3, -8'sd3, -8'sd3, -8'sd3, -8'sd3, -8'sd3};
`else
    ea = '{8'sd2, -8'sd2, 8'sd2, -8'sd2, 8'sd3, 8'sd2};
    eb = '{8'sd4, -8'sd4, -8'sd4, -8'sd4, -8'sd4, -8'sd4};
`endif
    test_reset();
    test_directed("basic", qa, ea);
    test_directed("tie_sat", qb, eb);
    test_backpressure();
    test_back_to_back();
    test_random_gaps();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
